// File: rtl/fir_tap_sequencer.sv
// FIR front-end: circular sample RAM, tap streaming into an external MAC, rounding.
// Optional FIR_SEQ_SATURATE_EN clamps the rounded result instead of wrapping.
module fir_tap_sequencer #(
    parameter int TAPS    = 256,
    parameter int ADDR_W  = 8,
    parameter int DECIM   = 8,
    parameter int MAC_LAT = 4,
    parameter int SHIFT   = 23
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [23:0]       in_data,
    input  logic              in_strobe,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic [23:0]       coef_data,
    output logic              mac_clear,
    output logic [23:0]       mac_data_1,
    output logic [23:0]       mac_data_2,
    input  logic [55:0]       mac_result,
    output logic [23:0]       out_data,
    output logic              out_strobe,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int CNT_W = ADDR_W + 1;
    localparam int DRN_W = $clog2(MAC_LAT + 1) + 1;
    localparam logic [CNT_W-1:0]  DEC_LAST = CNT_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(TAPS - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(MAC_LAT);

    state_t state, state_nx;

    logic [23:0]       ram [TAPS];
    logic [23:0]       ram_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] base, base_nx;
    logic [ADDR_W-1:0] k, k_nx;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  dec_cnt;
    logic [DRN_W-1:0]  drn, drn_nx;
    logic              trig;
    logic              win;
    logic              clr_nx;
    logic              strobe_nx;
    logic [23:0]       data_nx;
    logic [55:0]       rnd;
    logic [23:0]       result;
    logic              unused_rnd;

    assign trig      = in_strobe && (dec_cnt == DEC_LAST);
    assign rd_addr   = base - k;
    assign busy      = (state != IDLE);
    assign coef_addr = k;

    // Operands are only live for the TAPS cycles after the RAM read latency
    assign mac_data_1 = win ? ram_q : 24'd0;
    assign mac_data_2 = win ? coef_data : 24'd0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            dec_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            if (in_strobe) begin
                wr_ptr  <= wr_ptr + 1'b1;
                dec_cnt <= trig ? '0 : dec_cnt + 1'b1;
            end
            if (trig && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (in_strobe) begin
            ram[wr_ptr] <= in_data;
        end
        ram_q <= ram[rd_addr];
    end

    assign rnd = mac_result + (56'd1 << (SHIFT - 1));

`ifdef FIR_SEQ_SATURATE_EN
    logic [55-SHIFT-23:0] hi;
    logic                 ovf;
    assign hi         = rnd[55:SHIFT+23];
    assign ovf        = !((&hi) || !(|hi));
    assign result     = ovf ? (rnd[55] ? 24'h800000 : 24'h7FFFFF)
                            : rnd[SHIFT+23:SHIFT];
    assign unused_rnd = ^rnd[SHIFT-1:0];
`else
    assign result     = rnd[SHIFT+23:SHIFT];
    assign unused_rnd = ^{rnd[55:SHIFT+24], rnd[SHIFT-1:0]};
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            base       <= '0;
            k          <= '0;
            drn        <= '0;
            win        <= 1'b0;
            mac_clear  <= 1'b1;
            out_strobe <= 1'b0;
            out_data   <= '0;
        end else begin
            state      <= state_nx;
            base       <= base_nx;
            k          <= k_nx;
            drn        <= drn_nx;
            win        <= (state == RUN);
            mac_clear  <= clr_nx;
            out_strobe <= strobe_nx;
            out_data   <= data_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        base_nx   = base;
        k_nx      = k;
        drn_nx    = drn;
        clr_nx    = mac_clear;
        strobe_nx = 1'b0;
        data_nx   = out_data;
        unique case (state)
            IDLE: begin
                if (trig) begin
                    state_nx = RUN;
                    base_nx  = wr_ptr;
                    k_nx     = '0;
                    clr_nx   = 1'b0;
                end
            end
            RUN: begin
                k_nx = k + 1'b1;
                if (k == K_LAST) begin
                    state_nx = DRAIN;
                    drn_nx   = '0;
                end
            end
            DRAIN: begin
                if (drn == DRN_LAST) begin
                    state_nx = DONE;
                end else begin
                    drn_nx = drn + 1'b1;
                end
            end
            DONE: begin
                // Clear is registered so the MAC's async clear lands after capture
                state_nx  = IDLE;
                clr_nx    = 1'b1;
                strobe_nx = 1'b1;
                data_nx   = result;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a behavioural MAC and output model.
// Builds with or without FIR_SEQ_SATURATE_EN to match the DUT.
module tb_fir_tap_sequencer;

    localparam int TAPS  = 256;
    localparam int DECIM = 8;
    localparam int LAT   = 263;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_strobe = 1'b0;
    logic [7:0]  coef_addr;
    logic [23:0] coef_data = '0;
    logic        mac_clear;
    logic [23:0] mac_data_1;
    logic [23:0] mac_data_2;
    logic [55:0] mac_result;
    logic [23:0] out_data;
    logic        out_strobe;
    logic        busy;
    logic        overrun;

    always #5 clock = ~clock;

    fir_tap_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_strobe  (in_strobe),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .mac_clear  (mac_clear),
        .mac_data_1 (mac_data_1),
        .mac_data_2 (mac_data_2),
        .mac_result (mac_result),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .busy       (busy),
        .overrun    (overrun)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input longint got, input longint want);
        nchk++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Coefficient ROM, one cycle latency
    logic [23:0] coef [TAPS];
    always @(posedge clock) coef_data <= coef[coef_addr];

    // MAC: 3-stage multiplier then accumulator
    logic signed [47:0] p1 = '0, p2 = '0, p3 = '0;
    logic signed [55:0] acc = '0;
    always @(posedge clock) begin
        if (mac_clear) begin
            p1 <= '0; p2 <= '0; p3 <= '0; acc <= '0;
        end else begin
            p1  <= $signed(mac_data_1) * $signed(mac_data_2);
            p2  <= p1;
            p3  <= p2;
            acc <= acc + {{8{p3[47]}}, p3};
        end
    end
    assign mac_result = acc;

    // Output model: memory image, trigger bookkeeping, expected results
    typedef struct {
        int          due;
        bit          ok;
        logic [23:0] val;
    } exp_t;

    logic [23:0] mem [TAPS];
    bit          known [TAPS];
    exp_t        expq [$];
    int          cyc = 0;
    int          wp = 0;
    int          nstrobe = 0;
    int          last_trig = -1000;
    bit          m_over = 1'b0;

    function automatic void model_out(input int base, output bit ok,
                                      output logic [23:0] v);
        longint s, q;
        int     a;
        s  = 0;
        ok = 1'b1;
        for (int k = 0; k < TAPS; k++) begin
            a = ((base - k) % TAPS + TAPS) % TAPS;
            if (!known[a]) ok = 1'b0;
            s += longint'($signed(mem[a])) * longint'($signed(coef[k]));
        end
        q = (s + (64'sd1 <<< 22)) >>> 23;
`ifdef FIR_SEQ_SATURATE_EN
        if (q > 64'sd8388607) q = 64'sd8388607;
        if (q < -64'sd8388608) q = -64'sd8388608;
`endif
        v = q[23:0];
    endfunction

    always @(posedge clock) begin
        bit          ok;
        logic [23:0] v;
        if (!reset_n) begin
            wp = 0; nstrobe = 0; m_over = 1'b0; last_trig = -1000;
            expq.delete();
        end else if (in_strobe) begin
            mem[wp]   = in_data;
            known[wp] = 1'b1;
            nstrobe++;
            if (nstrobe % DECIM == 0) begin
                if (cyc >= last_trig + LAT) begin
                    last_trig = cyc;
                    model_out(wp, ok, v);
                    expq.push_back('{due: cyc + LAT, ok: ok, val: v});
                end else begin
                    m_over = 1'b1;
                end
            end
            wp = (wp + 1) % TAPS;
        end
        cyc++;
    end

    always @(negedge reset_n) begin
        wp = 0; nstrobe = 0; m_over = 1'b0; last_trig = -1000;
        expq.delete();
    end

    int          nout = 0;
    int          strobe_cyc = 0;
    logic [23:0] last_out = '0;

    always @(negedge clock) begin
        bit   es, bm;
        exp_t e;
        while (expq.size() > 0 && expq[0].due < cyc) void'(expq.pop_front());
        es = expq.size() > 0 && expq[0].due == cyc;
        bm = (cyc > last_trig) && (cyc <= last_trig + LAT - 1);
        chk("out_strobe", out_strobe, es);
        chk("busy", busy, bm);
        chk("mac_clear", mac_clear, !bm);
        chk("overrun", overrun, m_over);
        if (out_strobe) begin
            nout++;
            last_out   = out_data;
            strobe_cyc = cyc;
        end
        if (es) begin
            e = expq.pop_front();
            if (e.ok) chk("out_data", out_data, e.val);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic burst(input logic [23:0] v, input logic [23:0] last,
                         output int tcyc);
        tcyc = 0;
        for (int i = 0; i < DECIM; i++) begin
            in_strobe = 1'b1;
            in_data   = (i == DECIM - 1) ? last : v;
            if (i == DECIM - 1) tcyc = cyc;
            tick(1);
        end
        in_strobe = 1'b0;
        in_data   = '0;
    endtask

    task automatic run(input logic [23:0] v, input logic [23:0] last);
        int t;
        burst(v, last, t);
        tick(275);
    endtask

    task automatic set_coef(input int mode);
        for (int k = 0; k < TAPS; k++) begin
            unique case (mode)
                0: coef[k] = 24'h008000;
                1: coef[k] = 24'(k + 1);
                default: coef[k] = 24'h7FFFFF;
            endcase
        end
    endtask

    initial begin
        int t, t2, n0;
        set_coef(0);
        tick(3);
        chk("rst_mac_clear", mac_clear, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_strobe", out_strobe, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_coef_addr", coef_addr, 0);
        chk("rst_mac_data_1", mac_data_1, 0);
        chk("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        tick(2);

        // DC: 256 samples of 0.125 against 1/256 coefficients
        repeat (32) run(24'h100000, 24'h100000);
        chk("dc_out", last_out, 24'h100000);
        chk("dc_count", nout, 32);

        burst(24'h100000, 24'h100000, t);
        tick(275);
        chk("latency", strobe_cyc - t, 263);

        // Second trigger 100 cycles into the first run
        n0 = nout;
        burst(24'h100000, 24'h100000, t);
        tick(92);
        burst(24'h100000, 24'h100000, t2);
        tick(275);
        chk("ovr_gap", t2 - t, 100);
        chk("ovr_flag", overrun, 1);
        chk("ovr_count", nout - n0, 1);
        chk("ovr_value", last_out, 24'h100000);

        reset_n = 1'b0;
        tick(2);
        chk("ovr_cleared", overrun, 0);
        reset_n = 1'b1;
        tick(2);

        // First cycle after DONE accepts a new trigger
        n0 = nout;
        burst(24'h100000, 24'h100000, t);
        tick(255);
        burst(24'h100000, 24'h100000, t2);
        tick(275);
        chk("b2b_gap", t2 - t, 263);
        chk("b2b_overrun", overrun, 0);
        chk("b2b_count", nout - n0, 2);

        // Trigger landing in the DONE cycle is dropped
        n0 = nout;
        burst(24'h100000, 24'h100000, t);
        tick(254);
        burst(24'h100000, 24'h100000, t2);
        tick(275);
        chk("done_gap", t2 - t, 262);
        chk("done_overrun", overrun, 1);
        chk("done_count", nout - n0, 1);

        // Reset at tap 120 of RUN
        n0 = nout;
        burst(24'h100000, 24'h100000, t);
        tick(120);
        chk("mid_coef_addr", coef_addr, 120);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_mac_clear", mac_clear, 1);
        chk("mid_busy", busy, 0);
        chk("mid_overrun", overrun, 0);
        tick(2);
        reset_n = 1'b1;
        tick(300);
        chk("mid_no_strobe", nout - n0, 0);
        run(24'h100000, 24'h100000);
        chk("mid_recover", last_out, 24'h100000);
        chk("mid_recover_n", nout - n0, 1);

        // Impulse of 0.5 against ramp coefficients
        repeat (32) run(24'h000000, 24'h000000);
        set_coef(1);
        run(24'h000000, 24'h400000);
        chk("imp_tap0", last_out, 24'h000001);
        run(24'h000000, 24'h000000);
        chk("imp_tap8", last_out, 24'h000005);
        run(24'h000000, 24'h000000);
        chk("imp_tap16", last_out, 24'h000009);

        // Full-scale samples and coefficients
        set_coef(2);
        repeat (32) run(24'h7FFFFF, 24'h7FFFFF);
`ifdef FIR_SEQ_SATURATE_EN
        chk("sat_out", last_out, 24'h7FFFFF);
`else
        chk("sat_out", last_out, 24'hFFFE00);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
